// File: rtl/qmatmul_stream_if.sv
// ============================================================================
// Module   : qmatmul_stream_if
// Load and result valid/ready channels of the streaming matrix multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface qmatmul_stream_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

`default_nettype wire

// File: rtl/qmatmul_stream.sv
// ============================================================================
// Module   : qmatmul_stream
// Streaming signed fixed-point NxN matrix multiply, C = A*B, one shared MAC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module qmatmul_stream #(
    parameter int N = 4,
    parameter int W = 16,
    parameter int Q = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    qmatmul_stream_if.slave  bus,
    output      logic        busy,
    output      logic        ovf
);
    localparam int c_CW = $clog2(N);
    localparam int c_IW = $clog2(N * N);
    localparam int c_AW = 2 * W - Q + $clog2(N) + 1;

    localparam logic [c_CW-1:0] c_LAST     = c_CW'(N - 1);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(N * N - 1);
    localparam logic [c_IW-1:0] c_NI       = c_IW'(N);

    localparam logic signed [c_AW-1:0] c_SAT_MAX = {{(c_AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [c_AW-1:0] c_SAT_MIN = {{(c_AW - W + 1){1'b1}}, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MAC  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [W-1:0]           r_mem_a [N*N];
    logic [W-1:0]           r_mem_b [N*N];
    logic [c_IW-1:0]        r_load_idx;
    logic [c_CW-1:0]        r_i;
    logic [c_CW-1:0]        r_j;
    logic [c_CW-1:0]        r_k;
    logic signed [c_AW-1:0] r_acc;
    logic                   r_ovf;

    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_out_last;
    logic                   w_busy;
    logic                   w_load_fire;
    logic                   w_emit_fire;
    logic [c_IW-1:0]        w_a_addr;
    logic [c_IW-1:0]        w_b_addr;
    logic signed [W-1:0]    w_a_elem;
    logic signed [W-1:0]    w_b_elem;
    logic signed [2*W-1:0]  w_prod;
    logic signed [c_AW-1:0] w_term;
    logic [W-1:0]           w_sat;
    logic                   w_clamp;

    assign w_a_addr = c_IW'(r_i) * c_NI + c_IW'(r_k);
    assign w_b_addr = c_IW'(r_k) * c_NI + c_IW'(r_j);
    assign w_a_elem = r_mem_a[w_a_addr];
    assign w_b_elem = r_mem_b[w_b_addr];

    // Full-width product, then arithmetic shift: truncation rounds toward -inf.
    assign w_prod = (2*W)'(w_a_elem) * (2*W)'(w_b_elem);
    assign w_term = c_AW'(w_prod >>> Q);

    always_comb begin
        w_sat   = r_acc[W-1:0];
        w_clamp = 1'b0;
        if (r_acc > c_SAT_MAX) begin
            w_sat   = {1'b0, {(W - 1){1'b1}}};
            w_clamp = 1'b1;
        end else if (r_acc < c_SAT_MIN) begin
            w_sat   = {1'b1, {(W - 1){1'b0}}};
            w_clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (r_load_idx == c_LAST_IDX)) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                w_busy = 1'b1;
                if (r_k == c_LAST) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                w_out_last  = (r_i == c_LAST) && (r_j == c_LAST);
                if (bus.out_ready) begin
                    w_state_nxt = w_out_last ? S_LOAD : S_MAC;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    assign w_load_fire = bus.in_valid && w_in_ready;
    assign w_emit_fire = w_out_valid && bus.out_ready;

    // Operand storage carries no reset: every slot is rewritten by the next load.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem_a[r_load_idx] <= bus.in_a;
            r_mem_b[r_load_idx] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_idx <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_load_fire) begin
                        if (r_load_idx == '0) begin
                            r_ovf <= 1'b0;
                        end
                        if (r_load_idx == c_LAST_IDX) begin
                            r_load_idx <= '0;
                            r_i        <= '0;
                            r_j        <= '0;
                            r_k        <= '0;
                            r_acc      <= '0;
                        end else begin
                            r_load_idx <= r_load_idx + c_IW'(1);
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term;
                    r_k   <= (r_k == c_LAST) ? '0 : r_k + c_CW'(1);
                end
                S_EMIT: begin
                    if (w_clamp) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_emit_fire) begin
                        r_acc <= '0;
                        r_k   <= '0;
                        if (r_j == c_LAST) begin
                            r_j <= '0;
                            r_i <= (r_i == c_LAST) ? '0 : r_i + c_CW'(1);
                        end else begin
                            r_j <= r_j + c_CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_last;
    assign bus.out_data  = (r_state == S_EMIT) ? w_sat : '0;
    assign busy          = w_busy;
    assign ovf           = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_qmatmul_stream.sv
// ============================================================================
// Module   : tb_qmatmul_stream
// Directed self-checking bench for qmatmul_stream (4x4 Q8.8 and 3x3 W12 Q4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_qmatmul_stream;
    logic clk = 1'b0;
    logic reset;
    logic busy, ovf, busy3, ovf3;

    qmatmul_stream_if #(.W(16)) bus ();
    qmatmul_stream_if #(.W(12)) bus3 ();

    qmatmul_stream #(.N(4), .W(16), .Q(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .ovf(ovf)
    );
    qmatmul_stream #(.N(3), .W(12), .Q(4)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .busy(busy3), .ovf(ovf3)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] ma [16];
    logic [15:0] mb [16];
    logic [15:0] exp16 [16];
    logic [15:0] got_data [16];
    logic        got_last [16];
    logic        ovf_first;
    int          a3 [9];
    int          b3 [9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_identity();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r*4+c]    = (r == c) ? 16'h0100 : 16'h0000;
                mb[r*4+c]    = 16'(16 * (4 * r + c + 1));
                exp16[r*4+c] = 16'(16 * (4 * r + c + 1));
            end
        end
    endtask

    task automatic fill(input logic [15:0] va, input logic [15:0] vb, input logic [15:0] ve);
        for (int x = 0; x < 16; x++) begin
            ma[x] = va; mb[x] = vb; exp16[x] = ve;
        end
    endtask

    // Returns just after the posedge that accepted the last beat.
    task automatic load16(input bit gaps);
        int idx   = 0;
        int guard = 0;
        logic hs;
        while (idx < 16 && guard < 500) begin
            @(negedge clk);
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_a     = ma[idx];
            bus.in_b     = mb[idx];
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (hs) begin
                if (idx == 0) begin
                    #1 ovf_first = ovf;
                end
                idx++;
            end
            guard++;
        end
        if (idx < 16) check("load_timeout", 32'(idx), 32'd16);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic collect16(input int n, input int stall_idx);
        logic [15:0] held;
        for (int e = 0; e < n; e++) begin
            int w = 0;
            while (!bus.out_valid && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!bus.out_valid) begin
                check("out_timeout", 32'(w), 32'd0);
                return;
            end
            if (e == stall_idx) begin
                held = bus.out_data;
                repeat (7) begin
                    @(negedge clk);
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_data", 32'(bus.out_data), 32'(held));
                end
            end
            got_data[e]   = bus.out_data;
            got_last[e]   = bus.out_last;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
        end
    endtask

    task automatic compare16(input string name, input int n);
        for (int e = 0; e < n; e++) begin
            check($sformatf("%s_data%0d", name, e), 32'(got_data[e]), 32'(exp16[e]));
            check($sformatf("%s_last%0d", name, e), 32'(got_last[e]), 32'(e == 15));
        end
    endtask

    function automatic logic [11:0] gold3(input int i, input int j);
        longint acc = 0;
        for (int k = 0; k < 3; k++) begin
            acc += (longint'(a3[i*3+k]) * longint'(b3[k*3+j])) >>> 4;
        end
        if (acc > 2047) acc = 2047;
        else if (acc < -2048) acc = -2048;
        return 12'(acc);
    endfunction

    task automatic check_idle(input string name);
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_out_data"}, 32'(bus.out_data), 32'd0);
        check({name, "_out_last"}, 32'(bus.out_last), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n3;
        int cyc;
        int last_cyc;
        logic [11:0] got3 [9];

        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b0;
        bus3.in_valid  = 1'b0;
        bus3.in_a      = '0;
        bus3.in_b      = '0;
        bus3.out_ready = 1'b1;
        ovf_first      = 1'b1;

        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // Identity: C must equal B, first result 5 negedges after the last load edge.
        set_identity();
        load16(1'b0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                check("mac_busy", 32'(busy), 32'd1);
                check("mac_in_ready", 32'(bus.in_ready), 32'd0);
            end
        end while (!bus.out_valid && cnt < 20);
        check("first_valid_latency", 32'(cnt), 32'd5);
        collect16(16, -1);
        compare16("ident", 16);
        @(negedge clk);
        check("done_in_ready", 32'(bus.in_ready), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_out_valid", 32'(bus.out_valid), 32'd0);
        check("ident_ovf", 32'(ovf), 32'd0);

        // Positive saturation: 4 * (0x7F00^2 >>> 8) far above 0x7FFF.
        fill(16'h7F00, 16'h7F00, 16'h7FFF);
        load16(1'b0);
        collect16(16, -1);
        compare16("satpos", 16);
        @(negedge clk);
        check("satpos_ovf", 32'(ovf), 32'd1);

        fill(16'h8000, 16'h7F00, 16'h8000);
        load16(1'b0);
        check("ovf_clear_first_beat", 32'(ovf_first), 32'd0);
        collect16(16, -1);
        compare16("satneg", 16);
        @(negedge clk);
        check("satneg_ovf", 32'(ovf), 32'd1);

        // Floor rounding: -1 LSB * 1 LSB >>> 8 = -1, +1 LSB product floors to 0.
        fill(16'h0000, 16'h0000, 16'h0000);
        ma[0] = 16'hFFFF; mb[0] = 16'h0001; exp16[0] = 16'hFFFF;
        load16(1'b0);
        check("round_ovf_clear", 32'(ovf_first), 32'd0);
        collect16(16, -1);
        compare16("round_neg", 16);

        ma[0] = 16'h0001; exp16[0] = 16'h0000;
        load16(1'b0);
        collect16(16, -1);
        compare16("round_pos", 16);

        // Gapped load plus a 7-cycle stall on the third result.
        set_identity();
        load16(1'b1);
        collect16(16, 2);
        compare16("bp", 16);

        // Reset on the second MAC cycle of element 5.
        load16(1'b0);
        collect16(4, -1);
        compare16("pre_rst", 4);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1 check_idle("async_rst");
        @(negedge clk);
        reset = 1'b0;
        load16(1'b0);
        collect16(16, -1);
        compare16("post_rst", 16);

        // 3x3, W=12, Q=4 with out_ready held high.
        for (int x = 0; x < 9; x++) begin
            a3[x] = int'($urandom_range(0, 255)) - 128;
            b3[x] = int'($urandom_range(0, 255)) - 128;
        end
        for (int x = 0; x < 9; x++) begin
            @(negedge clk);
            check("p3_in_ready", 32'(bus3.in_ready), 32'd1);
            bus3.in_valid = 1'b1;
            bus3.in_a     = 12'(a3[x]);
            bus3.in_b     = 12'(b3[x]);
            @(posedge clk);
        end
        #1 bus3.in_valid = 1'b0;
        n3 = 0;
        last_cyc = 0;
        for (cyc = 1; cyc <= 100 && last_cyc == 0; cyc++) begin
            @(negedge clk);
            if (bus3.out_valid) begin
                if (n3 < 9) got3[n3] = bus3.out_data;
                check($sformatf("p3_last%0d", n3), 32'(bus3.out_last), 32'(n3 == 8));
                n3++;
                if (bus3.out_last) last_cyc = cyc;
            end
        end
        check("p3_count", 32'(n3), 32'd9);
        check("p3_total_cycles", 32'(last_cyc), 32'd36);
        for (int x = 0; x < 9 && x < n3; x++) begin
            check($sformatf("p3_data%0d", x), 32'(got3[x]), 32'(gold3(x / 3, x % 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
